// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush sequencing, EX operand forwarding
// and saturating hazard counters for the five-stage pipeline.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [4:0]       id_addr1,
  input  logic [4:0]       id_addr2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [4:0]       ex_addr1,
  input  logic [4:0]       ex_addr2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_Wreg,
  input  logic             ex_Rmem,
  input  logic [4:0]       mem_rd,
  input  logic             mem_Wreg,
  input  logic [4:0]       wb_rd,
  input  logic             wb_Wreg,
  input  logic             branch_taken,
  input  logic             clr_cnt,
  output logic             stall,
  output logic             flush,
  output logic             flush_ifid,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic [CNT_W-1:0] lu_stalls,
  output logic [CNT_W-1:0] br_flushes
);
  typedef enum logic {RUN, REDIRECT} state_t;
  state_t state, state_nxt;
  logic lu, lu_inc;
  assign lu = ex_Rmem & ex_Wreg & (ex_rd != 5'd0) &
              ((id_use1 & (id_addr1 == ex_rd)) | (id_use2 & (id_addr2 == ex_rd)));
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) state <= RUN;
    else state <= state_nxt;
  // Outputs are gated by nReset so reset silences control immediately.
  always_comb begin
    state_nxt  = RUN;
    stall      = 1'b0;
    flush      = 1'b0;
    flush_ifid = 1'b0;
    lu_inc     = 1'b0;
    if (state == REDIRECT || branch_taken) begin
      flush      = nReset;
      flush_ifid = nReset;
      state_nxt  = branch_taken ? REDIRECT : RUN;
    end else if (lu) begin
      stall  = nReset;
      flush  = nReset;
      lu_inc = 1'b1;
    end
  end
  always_comb begin
    fwd1_sel = (mem_Wreg && mem_rd != 5'd0 && mem_rd == ex_addr1) ? 2'b01 :
               (wb_Wreg && wb_rd != 5'd0 && wb_rd == ex_addr1) ? 2'b10 : 2'b00;
    fwd2_sel = (mem_Wreg && mem_rd != 5'd0 && mem_rd == ex_addr2) ? 2'b01 :
               (wb_Wreg && wb_rd != 5'd0 && wb_rd == ex_addr2) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      lu_stalls  <= '0;
      br_flushes <= '0;
    end else begin
      lu_stalls  <= clr_cnt ? '0 : (lu_inc && !(&lu_stalls)) ? lu_stalls + 1'b1 : lu_stalls;
      br_flushes <= clr_cnt ? '0 : (branch_taken && !(&br_flushes)) ? br_flushes + 1'b1 : br_flushes;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It observes source and destination register fields in ID, EX, MEM and WB. It drives the `stall` that holds PC and the IF/ID register, and the `flush` that loads a bubble into the ID/EX register. It also generates the EX-stage operand-forwarding selects and keeps two saturating performance counters. A small state machine covers the extra wrong-path slot caused by the synchronous instruction memory after a taken branch.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- nReset  in  1  asynchronous active-low reset.
- id_addr1  in  5  rs1 field of the instruction in ID.
- id_addr2  in  5  rs2 field of the instruction in ID.
- id_use1  in  1  ID instruction reads rs1.
- id_use2  in  1  ID instruction reads rs2.
- ex_addr1  in  5  rs1 address held in ID/EX.
- ex_addr2  in  5  rs2 address held in ID/EX.
- ex_rd  in  5  destination of the EX instruction.
- ex_Wreg  in  1  EX instruction writes a register.
- ex_Rmem  in  1  EX instruction is a load.
- mem_rd  in  5  destination of the MEM instruction.
- mem_Wreg  in  1  MEM instruction writes a register.
- wb_rd  in  5  destination of the WB instruction.
- wb_Wreg  in  1  WB instruction writes a register.
- branch_taken  in  1  taken branch or jump resolved in EX this cycle.
- clr_cnt  in  1  synchronous clear of both counters.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  bubble into ID/EX.
- flush_ifid  out  1  bubble into IF/ID.
- fwd1_sel  out  2  EX operand 1 source: 00 register file, 01 MEM result, 10 WB result.
- fwd2_sel  out  2  EX operand 2 source, same encoding as fwd1_sel.
- lu_stalls  out  CNT_W  load-use stall cycles seen.
- br_flushes  out  CNT_W  taken branches seen.

## Operation
- States: RUN and REDIRECT.
- Load-use condition (LU): ex_Rmem & ex_Wreg & ex_rd≠0 & ((id_use1 & id_addr1==ex_rd) | (id_use2 & id_addr2==ex_rd)).
- RUN, branch_taken=1:
  - flush=1, flush_ifid=1, stall=0.
  - Next state REDIRECT.
  - br_flushes increments.
  - branch_taken has priority over LU; LU is ignored that cycle.
- RUN, LU=1 and branch_taken=0:
  - stall=1, flush=1, flush_ifid=0.
  - lu_stalls increments.
  - Stay in RUN.
  - The load moves to MEM and the stall clears the next cycle; the consumer enters EX when the load is in WB.
- RUN, otherwise: stall=0, flush=0, flush_ifid=0.
- REDIRECT:
  - flush=1, flush_ifid=1, stall=0. This kills the second wrong-path fetch.
  - LU is ignored.
  - Next state RUN, unless branch_taken=1. In that case stay in REDIRECT and increment br_flushes.
- Forwarding, evaluated for fwdN_sel with ex_addrN:
  - 01 if mem_Wreg & mem_rd≠0 & mem_rd==ex_addrN.
  - Else 10 if wb_Wreg & wb_rd≠0 & wb_rd==ex_addrN.
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded.
- Forwarding is purely combinational and independent of the state.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_cnt clears both to 0 and has priority over an increment in the same cycle.

## Timing
- Reset, while nReset is low:
  - state=RUN, lu_stalls=0, br_flushes=0.
  - stall=0, flush=0, flush_ifid=0.
  - fwd selects still follow their inputs combinationally.
- stall, flush, flush_ifid and fwd selects are combinational from the current state and inputs, with zero-cycle latency.
- Counters and state update on the rising Clock edge after the qualifying cycle.
- Reset asserted while in REDIRECT returns to RUN immediately. No flush is asserted after release unless branch_taken is high.
- LU never lasts more than one consecutive cycle given a well-formed pipeline. If LU holds for N cycles, stall is held for N cycles and lu_stalls increments by N.

## Test plan
- Load x5 in EX, ID reads x5 as rs2 with id_use2=1 -> stall=1, flush=1 for exactly one cycle; lu_stalls 0->1. Same case with ex_rd=0 -> no stall.
- branch_taken pulse at cycle t in RUN -> flush=flush_ifid=1 at t and t+1, 0 at t+2; br_flushes=1.
- branch_taken together with LU -> stall=0, flush=1, flush_ifid=1; lu_stalls unchanged.
- mem_rd=wb_rd=ex_addr1=7, both Wreg=1 -> fwd1_sel=01. Drop mem_Wreg -> 10. Set ex_addr1=0 with matching rd=0 -> 00.
- Preload lu_stalls near all-ones (CNT_W=4): force 20 LU cycles -> holds at 4'hF. clr_cnt together with an LU -> 0.
- nReset low during REDIRECT -> all control outputs 0 and counters 0 immediately; after release with idle inputs, flush stays 0.
